// File: rtl/en_pulse_gen.sv
// Push-button conditioner: two-flop synchroniser, counter debounce, and a
// press/auto-repeat FSM producing single-cycle enable pulses for a counter.
module en_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic en,
    output logic pressed
);

    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] DELAY_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RATE_LAST  = 16'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic        s1_q;
    logic        s2_q;
    logic        pressed_q;
    logic        pressed_d;
    logic [15:0] dcnt_q;
    logic [15:0] dcnt_d;
    logic [15:0] rcnt_q;
    logic [15:0] rcnt_d;
    logic        en_q;
    logic        en_d;
    state_t      state_q;
    state_t      state_d;
    logic        rise;
    logic        fall;

    always_comb begin
        pressed_d = pressed_q;
        dcnt_d    = '0;
        if (s2_q != pressed_q) begin
            if (dcnt_q == DEB_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                dcnt_d = dcnt_q + 16'd1;
            end
        end
    end

    // Edges are taken from the debounce next-state so the pulse lands on the
    // same clock edge as the level change of pressed.
    assign rise = pressed_d & ~pressed_q;
    assign fall = ~pressed_d & pressed_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        en_d    = 1'b0;
        if (fall) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (rise) begin
                        en_d    = 1'b1;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (!repeat_en) begin
                        rcnt_d = '0;
                    end else if (rcnt_q == DELAY_LAST) begin
                        en_d    = 1'b1;
                        rcnt_d  = '0;
                        state_d = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q + 16'd1;
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        rcnt_d  = '0;
                        state_d = DELAY;
                    end else if (rcnt_q == RATE_LAST) begin
                        en_d   = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 16'd1;
                    end
                end
                default: begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            pressed_q <= 1'b0;
            dcnt_q    <= '0;
            rcnt_q    <= '0;
            en_q      <= 1'b0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            pressed_q <= pressed_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            en_q      <= en_d;
            state_q   <= state_d;
        end
    end

    assign en      = en_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_en_pulse_gen.sv
// Self-checking bench for en_pulse_gen: scenario table, directed corner cases,
// and randomized button traffic compared against a timestamp-based model.
module tb_en_pulse_gen;

    localparam int D     = 4;
    localparam int DLY   = 16;
    localparam int RATE  = 8;

    logic clk;
    logic reset;
    logic btn;
    logic repeat_en;
    logic en;
    logic pressed;
    logic [7:0] cnt8;

    int tests;
    int fails;

    en_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .repeat_en(repeat_en),
        .en(en),
        .pressed(pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 8-bit up-counter driven by en.
    always @(posedge clk or posedge reset) begin
        if (reset) cnt8 <= 8'd0;
        else if (en) cnt8 <= cnt8 + 8'd1;
    end

    // Reference model: pressed toggles once the last D synchronised samples all
    // disagree with it; pulses fire at timestamped deadlines while held.
    int m_cyc;
    bit m_s1, m_s2, m_pressed, m_en;
    int m_deadline;
    bit hist[$];

    task automatic model_step();
        bit bs;
        bit all_dis;
        if (reset) begin
            m_cyc = 0; m_s1 = 0; m_s2 = 0; m_pressed = 0; m_en = 0;
            m_deadline = 0;
            hist.delete();
        end else begin
            m_cyc++;
            bs   = m_s2;
            m_s2 = m_s1;
            m_s1 = btn;
            hist.push_front(bs);
            if (hist.size() > D) void'(hist.pop_back());
            all_dis = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == m_pressed) all_dis = 0;
            m_en = 0;
            if (all_dis) begin
                m_pressed = !m_pressed;
                if (m_pressed) begin
                    m_en = 1;
                    m_deadline = m_cyc + DLY;
                end
            end else if (m_pressed) begin
                if (!repeat_en) begin
                    m_deadline = m_cyc + DLY;
                end else if (m_cyc == m_deadline) begin
                    m_en = 1;
                    m_deadline = m_cyc + RATE;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive btn high for edges 1..high_len, low afterwards, for total edges.
    task automatic run_press(input int high_len, input int total, input bit rep,
                             output int pulses, output int first, output bit pend);
        pulses = 0;
        first  = -1;
        for (int e = 1; e <= total; e++) begin
            @(negedge clk);
            btn = (e <= high_len);
            repeat_en = rep;
            @(posedge clk);
            #1;
            if (en) begin
                pulses++;
                if (first < 0) first = e;
            end
        end
        pend = pressed;
    endtask

    typedef struct {
        int high_len;
        bit rep;
        int exp_pulses;
        int exp_first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pulses, first;
        bit pend;
        bit any_p, any_e;
        int run_left;

        tests = 0;
        fails = 0;
        vecs[0] = '{3,  1'b1, 0, -1};
        vecs[1] = '{4,  1'b1, 1, 6};
        vecs[2] = '{40, 1'b1, 4, 6};
        vecs[3] = '{60, 1'b0, 1, 6};
        vecs[4] = '{21, 1'b1, 2, 6};
        vecs[5] = '{16, 1'b1, 1, 6};
        vecs[6] = '{17, 1'b1, 2, 6};
        vecs[7] = '{48, 1'b1, 5, 6};

        reset = 1'b1;
        btn = 1'b1;
        repeat_en = 1'b1;

        // Reset with button held: outputs stay low, then one press pulse after release.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset_en", en, 0);
            check("reset_pressed", pressed, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        first = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (en) begin
                pulses++;
                if (first < 0) first = e;
            end
            @(negedge clk);
        end
        check("post_reset_first", first, 6);
        check("post_reset_pulses", pulses, 1);
        btn = 1'b0;
        repeat (20) @(negedge clk);

        foreach (vecs[k]) begin
            run_press(vecs[k].high_len, vecs[k].high_len + 20, vecs[k].rep,
                      pulses, first, pend);
            check($sformatf("vec%0d_pulses", k), pulses, vecs[k].exp_pulses);
            check($sformatf("vec%0d_first", k), first, vecs[k].exp_first);
            check($sformatf("vec%0d_released", k), int'(pend), 0);
        end
        repeat_en = 1'b1;

        // Bouncing every cycle must never qualify.
        any_p = 0;
        any_e = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn = i[0];
            @(posedge clk);
            #1;
            if (pressed) any_p = 1;
            if (en) any_e = 1;
        end
        check("bounce_pressed", int'(any_p), 0);
        check("bounce_en", int'(any_e), 0);
        @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);

        // Reset mid-hold: outputs clear immediately, new press follows release.
        btn = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("midhold_pressed_before", pressed, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midhold_en_async", en, 0);
        check("midhold_pressed_async", pressed, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        first = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (en && first < 0) first = e;
        end
        check("midhold_new_press", first, 6);
        @(negedge clk);
        btn = 1'b0;
        repeat (20) @(negedge clk);

        // System test with the up-counter.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 5; p++) begin
            run_press(10, 25, 1'b0, pulses, first, pend);
        end
        check("counter_value", int'(cnt8), 5);

        // Randomized traffic against the model.
        repeat_en = 1'b1;
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 999) < 3) reset = 1'b1;
            if (run_left == 0) begin
                btn = ~btn;
                run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                       : $urandom_range(5, 60);
            end
            run_left--;
            if ($urandom_range(0, 99) < 4) repeat_en = ~repeat_en;
            @(posedge clk);
            #1;
            check("rand_en", en, int'(m_en));
            check("rand_pressed", pressed, int'(m_pressed));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
